out_pixel_serializer: RTL and testbench

- Sits directly downstream of the decoder output sync FIFO, in the read clock domain.
- Pulls 4-pixel words from the FIFO with a read enable, absorbing the FIFO's 1-cycle RAM read latency.
- Serializes each word into one pixel per cycle on a valid/ready stream, marking start-of-frame, end-of-line and end-of-frame from programmed slice dimensions.
- Holds off after each frame start until the FIFO has prefilled, to avoid early underflow.

---
 rtl/vdcm_out_pkg.sv | 21 ++
 rtl/word_skid_buf.sv | 49 ++++
 rtl/out_pixel_serializer.sv | 144 ++++++++++++++
 tb/tb_out_pixel_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdcm_out_pkg.sv
// Shared constants, pixel/word payload types and serializer state encoding
// for the decoder output pixel path.
package vdcm_out_pkg;

  localparam int unsigned PIXELS_PER_WORD    = 4;
  localparam int unsigned BITS_PER_COMPONENT = 14;
  localparam int unsigned PIXEL_WIDTH        = 3 * BITS_PER_COMPONENT;
  localparam int unsigned WORD_WIDTH         = PIXELS_PER_WORD * PIXEL_WIDTH;
  localparam int unsigned PIX_IDX_W          = $clog2(PIXELS_PER_WORD);

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  // Index 0 sits in the LSBs, matching the FIFO word packing.
  typedef pixel_t [PIXELS_PER_WORD-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    STREAM  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/word_skid_buf.sv
// Two-entry word buffer between the FIFO read port and the pixel mux.
// Push and pop may happen in the same cycle; flush drops all entries.
module word_skid_buf
  import vdcm_out_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  word_t      push_data,
  input  logic       pop,
  output word_t      head,
  output logic [1:0] occupancy
);

  word_t      mem [0:1];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_push   = push & (count != 2'd2);
  assign do_pop    = pop & (count != 2'd0);
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/out_pixel_serializer.sv
// Pulls 4-pixel words from the output sync FIFO and streams one pixel per
// cycle with sof/eol/eof markers derived from the programmed slice size.
module out_pixel_serializer
  import vdcm_out_pkg::*;
#(
  parameter int unsigned MAX_SLICE_WIDTH  = 2560,
  parameter int unsigned MAX_SLICE_HEIGHT = 2560,
  parameter int unsigned PREFILL_TIMEOUT  = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
  input  logic [WORD_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  input  logic                                in_sof,
  input  logic                                fifo_empty,
  input  logic                                fifo_almost_empty,
  output logic                                fifo_rd_en,
  output logic [PIXEL_WIDTH-1:0]              out_pixel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                out_eof,
  output logic                                underflow
);

  localparam int unsigned COL_W = $clog2(MAX_SLICE_WIDTH);
  localparam int unsigned ROW_W = $clog2(MAX_SLICE_HEIGHT);
  localparam int unsigned PF_W  = $clog2(PREFILL_TIMEOUT);

  ser_state_t           state;
  ser_state_t           next_state;
  logic                 in_sof_q;
  logic                 sof_rise;
  logic                 inflight;
  logic [COL_W-1:0]     x;
  logic [ROW_W-1:0]     y;
  logic [PF_W-1:0]      pf_cnt;
  logic [1:0]           occupancy;
  word_t                head;
  logic [PIX_IDX_W-1:0] pix_idx;
  logic                 streaming;
  logic                 buf_empty;
  logic                 handshake;
  logic                 eol;
  logic                 eof;
  logic                 pop;
  logic                 push;
  logic                 prefill_done;

  assign sof_rise  = in_sof & ~in_sof_q;
  assign streaming = (state == STREAM);
  assign buf_empty = (occupancy == 2'd0);
  // Lines always start on a word boundary, so the low column bits are the pixel slot.
  assign pix_idx   = x[PIX_IDX_W-1:0];
  assign eol       = (x == slice_width - COL_W'(1));
  assign eof       = eol & (y == slice_height - ROW_W'(1));
  assign handshake = streaming & ~buf_empty & out_ready;
  assign pop       = handshake & (eol | (pix_idx == PIX_IDX_W'(PIXELS_PER_WORD - 1)));
  assign push      = in_valid & inflight;
  assign prefill_done = ~in_sof &
                        (~fifo_almost_empty | (pf_cnt == PF_W'(PREFILL_TIMEOUT - 1)));

  word_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (sof_rise),
    .push      (push),
    .push_data (word_t'(in_data)),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and stream outputs; a new frame start overrides everything.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    underflow  = 1'b0;
    fifo_rd_en = 1'b0;
    out_pixel  = '0;
    out_sof    = 1'b0;
    out_eol    = 1'b0;
    out_eof    = 1'b0;

    case (state)
      IDLE:    next_state = IDLE;
      PREFILL: if (prefill_done) next_state = STREAM;
      STREAM:  if (handshake & eof) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (sof_rise) next_state = PREFILL;

    out_valid  = streaming & ~buf_empty;
    underflow  = streaming & buf_empty;
    fifo_rd_en = streaming & ~fifo_empty & ((3'(occupancy) + 3'(inflight)) < 3'd2);
    if (out_valid) begin
      out_pixel = head[pix_idx];
      out_sof   = (x == '0) & (y == '0);
      out_eol   = eol;
      out_eof   = eof;
    end
  end

  // Frame-start edge detect, in-flight read tracking, position and prefill counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_sof_q <= 1'b0;
      inflight <= 1'b0;
      x        <= '0;
      y        <= '0;
      pf_cnt   <= '0;
    end else begin
      in_sof_q <= in_sof;

      if (sof_rise)        inflight <= 1'b0;
      else if (fifo_rd_en) inflight <= 1'b1;
      else if (in_valid)   inflight <= 1'b0;

      if (sof_rise) begin
        x <= '0;
        y <= '0;
      end else if (handshake) begin
        if (eol) begin
          x <= '0;
          y <= eof ? '0 : y + ROW_W'(1);
        end else begin
          x <= x + COL_W'(1);
        end
      end

      if (!sof_rise && state == PREFILL && !in_sof) pf_cnt <= pf_cnt + PF_W'(1);
      else                                          pf_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_out_pixel_serializer.sv
// Scoreboard bench: a FIFO model feeds random words, a frame model queues
// the expected pixel stream, and a monitor checks every accepted pixel.
module tb_out_pixel_serializer;

  typedef struct {
    logic [41:0] pix;
    bit          sof;
    bit          eol;
    bit          eof;
    bit          last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [11:0]  slice_width;
  logic [11:0]  slice_height;
  logic [167:0] in_data;
  logic         in_valid;
  logic         in_sof;
  logic         fifo_empty;
  logic         fifo_almost_empty;
  logic         fifo_rd_en;
  logic [41:0]  out_pixel;
  logic         out_valid;
  logic         out_ready;
  logic         out_sof;
  logic         out_eol;
  logic         out_eof;
  logic         underflow;

  logic [167:0] fifo_q [$];
  exp_t         exp_q [$];
  bit           force_empty;
  bit           force_ae;
  bit           rand_ready;
  int           compared;
  int           errs;
  int           rd_count;
  int           consumed;
  int           accepted;
  int           uf_seen;
  int           resync_gen;
  int           seen_gen;
  bit           stall_prev;
  logic [44:0]  stall_snap;

  out_pixel_serializer dut (
    .clk               (clk),
    .rst               (rst),
    .slice_width       (slice_width),
    .slice_height      (slice_height),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_sof            (in_sof),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_rd_en        (fifo_rd_en),
    .out_pixel         (out_pixel),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_sof           (out_sof),
    .out_eol           (out_eol),
    .out_eof           (out_eof),
    .underflow         (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty        = force_empty || (fifo_q.size() == 0);
  assign fifo_almost_empty = force_ae || (fifo_q.size() < 2);

  // FIFO model: read data returns one cycle after the read enable.
  always @(posedge clk) begin
    in_valid <= 1'b0;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      in_data  <= fifo_q.pop_front();
      in_valid <= 1'b1;
      rd_count = rd_count + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: scoreboard compare, stall stability, underflow and buffering bounds.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (resync_gen != seen_gen) begin
        seen_gen = resync_gen;
        consumed = rd_count;
      end
      if (underflow) begin
        uf_seen++;
        compared++;
        if (out_valid) begin
          errs++;
          $display("FAIL underflow_with_valid: out_valid=%0b required 0", out_valid);
        end
      end
      if (fifo_rd_en) begin
        compared++;
        if (rd_count + 1 - consumed > 2) begin
          errs++;
          $display("FAIL buffer_bound: outstanding=%0d required <=2", rd_count + 1 - consumed);
        end
      end
      if (stall_prev && !in_sof) begin
        compared++;
        if (!out_valid || {out_pixel, out_sof, out_eol, out_eof} !== stall_snap) begin
          errs++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", out_valid,
                   {out_pixel, out_sof, out_eol, out_eof}, stall_snap);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_snap = {out_pixel, out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        compared++;
        accepted++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_pixel: got %h sof=%0b eol=%0b eof=%0b required none",
                   out_pixel, out_sof, out_eol, out_eof);
        end else begin
          e = exp_q.pop_front();
          if (e.last) consumed++;
          if (out_pixel !== e.pix || out_sof !== e.sof || out_eol !== e.eol || out_eof !== e.eof) begin
            errs++;
            $display("FAIL pixel: got %h s%0b l%0b f%0b required %h s%0b l%0b f%0b", out_pixel,
                     out_sof, out_eol, out_eof, e.pix, e.sof, e.eol, e.eof);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint req);
    compared++;
    if (got != req) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, longint'(out_valid), 0);
    chk({name, "_rd_en"}, longint'(fifo_rd_en), 0);
    chk({name, "_flags"}, longint'({out_sof, out_eol, out_eof}), 0);
    chk({name, "_underflow"}, longint'(underflow), 0);
    chk({name, "_pixel"}, longint'(out_pixel), 0);
  endtask

  // Frame model: ceil(w/4) words per line, leftover slots of the last word unused.
  task automatic load_frame(input int w, input int h);
    logic [191:0] tmp;
    logic [167:0] line_words [$];
    exp_t         e;
    int           wpl;
    wpl = (w + 3) / 4;
    slice_width  = 12'(w);
    slice_height = 12'(h);
    for (int r = 0; r < h; r++) begin
      line_words.delete();
      for (int k = 0; k < wpl; k++) begin
        tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        line_words.push_back(tmp[167:0]);
        fifo_q.push_back(tmp[167:0]);
      end
      for (int c = 0; c < w; c++) begin
        e.pix  = 42'(line_words[c / 4] >> ((c % 4) * 42));
        e.sof  = (r == 0 && c == 0);
        e.eol  = (c == w - 1);
        e.eof  = e.eol && (r == h - 1);
        e.last = ((c % 4) == 3) || e.eol;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_sof();
    @(posedge clk); #1;
    in_sof = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  task automatic wait_accept(input string name, input int target);
    int n;
    n = 0;
    while (accepted < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (accepted < target) chk({name, "_accept_timeout"}, longint'(accepted), longint'(target));
  endtask

  task automatic wait_drain(input string name, input int rd_base, input int words);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_left"}, longint'(exp_q.size()), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_reads"}, longint'(rd_count - rd_base), longint'(words));
    chk({name, "_idle"}, longint'({out_valid, underflow, fifo_rd_en}), 0);
  endtask

  task automatic run_frame(input string name, input int w, input int h, input bit rnd);
    int rd_base;
    rd_base    = rd_count;
    rand_ready = rnd;
    out_ready  = 1'b1;
    load_frame(w, h);
    pulse_sof();
    wait_drain(name, rd_base, h * ((w + 3) / 4));
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    int rd_base;
    int n;
    int uf_base;
    compared = 0; errs = 0; rd_count = 0; consumed = 0; accepted = 0;
    uf_seen = 0; resync_gen = 0; seen_gen = 0; stall_prev = 1'b0; stall_snap = '0;
    rst = 1'b1; in_sof = 1'b0; out_ready = 1'b1; force_empty = 1'b0; force_ae = 1'b0;
    rand_ready = 1'b0; slice_width = 12'd8; slice_height = 12'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame("w8h2", 8, 2, 1'b0);
    run_frame("w6h1", 6, 1, 1'b0);
    run_frame("w13h3_rnd", 13, 3, 1'b1);
    run_frame("w4h2_rnd", 4, 2, 1'b1);

    // FIFO runs dry mid-line: bubbles and underflow, then the correct next pixel.
    rd_base = rd_count;
    load_frame(16, 2);
    pulse_sof();
    wait_accept("gap", accepted + 6);
    force_empty = 1'b1;
    uf_base = uf_seen;
    repeat (12) @(posedge clk);
    #1;
    force_empty = 1'b0;
    chk("gap_underflow_seen", longint'(uf_seen > uf_base), 1);
    wait_drain("gap", rd_base, 8);

    // Almost-empty held: streaming is forced after the prefill timeout.
    rd_base = rd_count;
    load_frame(8, 1);
    force_ae = 1'b1;
    pulse_sof();
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (fifo_rd_en) break;
      n++;
    end
    chk("prefill_timeout", longint'(n), 256);
    @(posedge clk); #1;
    force_ae = 1'b0;
    wait_drain("timeout", rd_base, 2);

    // Abort at y=1, x=3 with a new frame start; next frame must be clean.
    load_frame(16, 2);
    pulse_sof();
    wait_accept("abort", accepted + 19);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_sof = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_flushed_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    fifo_q.delete();
    resync_gen++;
    rd_base = rd_count;
    load_frame(4, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_sof = 1'b0;
    wait_drain("after_abort", rd_base, 2);

    // Reset in the middle of a frame clears every output on the next edge.
    load_frame(8, 2);
    pulse_sof();
    wait_accept("midrst", accepted + 5);
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    resync_gen++;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    run_frame("w5h3_rnd", 5, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

endmodule
